alu_muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for 8x8 unsigned MUL (16-bit product) and 8/8 unsigned DIV (quotient+remainder).

---
 rtl/alu_muldiv_seq.sv | 178 +++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Multi-cycle sequencer for 8x8 unsigned multiply (16-bit
//               product) and 8/8 unsigned restoring divide (quotient and
//               remainder). Each step uses the shared 8-bit ALU for one
//               add/subtract; the partial-result shifts are done locally.
//               While alu_sel=1 the CPU datapath routes alu_a/alu_b/alu_mode
//               to the ALU and returns alu_out/alu_cout in the same cycle.
// Ports       : clk, rst_n (async, active-low)
//               start/op/opa/opb  request (sampled only while idle)
//               busy/done/dz      status (done is a one-cycle pulse)
//               res_hi/res_lo     MUL product / DIV remainder,quotient
//               alu_sel/alu_a/alu_b/alu_mode/alu_cin  ALU request side
//               alu_out/alu_cout  ALU result (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq #(
    parameter logic [3:0] MODE_ADD = 4'b0100,
    parameter logic [3:0] MODE_SUB = 4'b0111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] opa,
    input  logic [7:0] opb,
    output logic       busy,
    output logic       done,
    output logic       dz,
    output logic [7:0] res_hi,
    output logic [7:0] res_lo,
    output logic       alu_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_mode,
    output logic       alu_cin,
    input  logic [7:0] alu_out,
    input  logic       alu_cout
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [2:0] r_cnt;
    logic       r_op;      // latched operation: 0=MUL, 1=DIV
    logic [7:0] r_hi;      // MUL: HI accumulator / DIV: partial remainder R
    logic [7:0] r_lo;      // MUL: multiplier LO   / DIV: quotient Q
    logic [7:0] r_m;       // MUL: multiplicand M  / DIV: divisor D

    logic       w_accept;
    logic       w_div_zero;
    logic [7:0] w_div_a;
    logic       w_div_take;
    logic [8:0] w_mul_sum;
    logic [7:0] w_hi_nxt;
    logic [7:0] w_lo_nxt;

    assign busy       = (r_state == S_RUN);
    assign alu_sel    = busy;
    assign alu_cin    = 1'b0;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_div_zero = op && (opb == 8'd0);

    // ------------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // Divide-by-zero completes at the accept edge without running
                if (start && !w_div_zero) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == 3'd7) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // ALU request and per-step combinational update
    // ------------------------------------------------------------------------
    // Restoring divide: shift the next dividend bit into the remainder
    assign w_div_a    = {r_hi[6:0], r_lo[7]};
    // If R[7] was set the shifted value is >= 256 > D, so the subtract always
    // succeeds even though the 8-bit ALU reports a borrow.
    assign w_div_take = r_hi[7] | ~alu_cout;
    // Shift-add multiply: keep the carry as the 9th bit of the partial sum
    assign w_mul_sum  = r_lo[0] ? {alu_cout, alu_out} : {1'b0, r_hi};

    always_comb begin
        alu_a    = 8'd0;
        alu_b    = 8'd0;
        alu_mode = 4'b0000;
        if (busy) begin
            alu_b    = r_m;
            alu_a    = r_op ? w_div_a : r_hi;
            alu_mode = r_op ? MODE_SUB : MODE_ADD;
        end
    end

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_op) begin
            w_hi_nxt = w_div_take ? alu_out : w_div_a;
            w_lo_nxt = {r_lo[6:0], w_div_take};
        end else begin
            w_hi_nxt = w_mul_sum[8:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[7:1]};
        end
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 3'd0;
            r_op   <= 1'b0;
            r_hi   <= 8'd0;
            r_lo   <= 8'd0;
            r_m    <= 8'd0;
            res_hi <= 8'd0;
            res_lo <= 8'd0;
            dz     <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                if (w_div_zero) begin
                    res_lo <= 8'hFF;
                    res_hi <= opa;
                    dz     <= 1'b1;
                    done   <= 1'b1;
                end else begin
                    dz    <= 1'b0;
                    r_cnt <= 3'd0;
                    r_op  <= op;
                    r_hi  <= 8'd0;
                    r_lo  <= op ? opa : opb;
                    r_m   <= op ? opb : opa;
                end
            end else if (busy) begin
                r_hi  <= w_hi_nxt;
                r_lo  <= w_lo_nxt;
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    res_hi <= w_hi_nxt;
                    res_lo <= w_lo_nxt;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_seq
// Description : Self-checking bench for alu_muldiv_seq. Provides a behavioural
//               shared ALU, issues directed MUL/DIV requests with
//               hand-computed results into a scoreboard queue; a monitor pops
//               and compares whenever done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

    localparam logic [3:0] C_MODE_ADD = 4'b0100;
    localparam logic [3:0] C_MODE_SUB = 4'b0111;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       op    = 1'b0;
    logic [7:0] opa   = 8'd0;
    logic [7:0] opb   = 8'd0;
    logic       busy, done, dz, alu_sel, alu_cin, alu_cout;
    logic [7:0] res_hi, res_lo, alu_a, alu_b, alu_out;
    logic [3:0] alu_mode;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       dz;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;

    alu_muldiv_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .busy     (busy),
        .done     (done),
        .dz       (dz),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .alu_sel  (alu_sel),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_mode (alu_mode),
        .alu_cin  (alu_cin),
        .alu_out  (alu_out),
        .alu_cout (alu_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU: ADD gives carry out, SUB gives borrow out
    always_comb begin
        {alu_cout, alu_out} = 9'd0;
        if (alu_mode == C_MODE_ADD)
            {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        else if (alu_mode == C_MODE_SUB)
            {alu_cout, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
    end

    task automatic check(input string name, input int got, input int expv);
        total++;
        if (got == expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, expv);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("res_hi", res_hi, e.hi);
                check("res_lo", res_lo, e.lo);
                check("dz", dz, e.dz);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_dz"}, dz, 0);
        check({tag, "_res"}, {res_hi, res_lo}, 0);
        check({tag, "_alu_sel"}, alu_sel, 0);
        check({tag, "_alu_ab"}, {alu_a, alu_b}, 0);
        check({tag, "_alu_mode"}, alu_mode, 0);
        check({tag, "_alu_cin"}, alu_cin, 0);
    endtask

    // mode 0: plain op; mode 1: pulse start with other operands at cycles 3,5;
    // mode 2: assert reset during step 4. Called on a negedge.
    task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ehi, input logic [7:0] elo,
                          input logic edz, input int mode);
        exp_t e;
        int   bc;
        int   lat;
        bit   seen;
        lat   = edz ? 0 : 8;
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        e.hi  = ehi;
        e.lo  = elo;
        e.dz  = edz;
        e.cyc = cyc + 1 + lat;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op    = 1'($urandom);
        opa   = 8'($urandom);
        opb   = 8'($urandom);
        bc    = 0;
        seen  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mode == 1) begin
                start = (i == 2) || (i == 4);
                if (start) begin
                    op  = ~o;
                    opa = 8'h33;
                    opb = 8'h44;
                end
            end
            if (mode == 2 && i == 3) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("mid_reset");
                e = q.pop_back();
                for (int j = 0; j < 3; j++) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            if (busy) bc++;
            check("alu_sel", alu_sel, (i < lat) ? 1 : 0);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
        check("busy_cycles", bc, lat);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 0);
        run_op(1'b0, 8'hFF,  8'hFF,  8'hFE, 8'h01, 1'b0, 0);
        run_op(1'b0, 8'd0,   8'd77,  8'h00, 8'h00, 1'b0, 0);
        run_op(1'b1, 8'd200, 8'd7,   8'h04, 8'h1C, 1'b0, 0);
        run_op(1'b1, 8'hFF,  8'h80,  8'h7F, 8'h01, 1'b0, 0);
        run_op(1'b1, 8'd7,   8'd200, 8'h07, 8'h00, 1'b0, 0);
        run_op(1'b1, 8'h5A,  8'h00,  8'h5A, 8'hFF, 1'b1, 0);
        run_op(1'b1, 8'd100, 8'd10,  8'h00, 8'h0A, 1'b0, 0);
        run_op(1'b0, 8'hC8,  8'h0D,  8'h0A, 8'h28, 1'b0, 1);
        run_op(1'b1, 8'hFE,  8'h03,  8'h02, 8'h54, 1'b0, 2);
        run_op(1'b0, 8'd6,   8'd7,   8'h00, 8'h2A, 1'b0, 0);

        for (int k = 0; k < 4; k++) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
